// File: rtl/sram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_resp_pkg
// Purpose : Shared constants and address/byte-merge helpers for the SRAM
//           responder.
// Rev     : 1.0  initial release
// ============================================================================
package sram_resp_pkg;

    localparam logic [31:0] c_DEFAULT_BASE_ADDR = 32'h1c00_0000;
    localparam logic [31:0] c_DEFAULT_OOR_DATA  = 32'hdead_beef;

    // Only meaningful when addr >= base; callers gate with in_range().
    function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                             input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

    // The lower-bound test comes first so the subtraction can never wrap.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
        return (addr >= base) && (word_idx(addr, base) < depth);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  we4);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = we4[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_resp_port.sv
`default_nettype none
// ============================================================================
// Module  : sram_resp_port
// Purpose : One initiator port: address range decode, word index and
//           registered read data.
// Rev     : 1.0  initial release
// ============================================================================
module sram_resp_port
    import sram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = c_DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [31:0] OOR_DATA    = c_DEFAULT_OOR_DATA,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_mem_word,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_in_range,
    output logic             o_err,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_rdata;

    assign o_in_range = in_range(i_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    assign o_idx      = IDX_W'(word_idx(i_addr, BASE_ADDR));
    assign o_err      = i_en & ~o_in_range;
    assign o_rdata    = r_rdata;

    // i_mem_word is the array contents before this edge's writes (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (i_en) begin
            r_rdata <= o_in_range ? i_mem_word : OOR_DATA;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sram_responder.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sram_responder
// Purpose : Dual-port (inst + data) SRAM responder over one shared word array
//           with byte-lane writes and out-of-range error tracking.
// Rev     : 1.0  initial release
// ============================================================================
module cpu_sram_responder
    import sram_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = c_DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 65536,
    parameter logic [31:0] OOR_DATA    = c_DEFAULT_OOR_DATA,
    parameter int          ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_sram_en,
    input  logic                 inst_sram_we,
    input  logic [31:0]          inst_sram_addr,
    input  logic [31:0]          inst_sram_wdata,
    output logic [31:0]          inst_sram_rdata,
    input  logic                 data_sram_en,
    input  logic [3:0]           data_sram_we,
    input  logic [31:0]          data_sram_addr,
    input  logic [31:0]          data_sram_wdata,
    output logic [31:0]          data_sram_rdata,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [31:0]          err_addr
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]          r_mem [DEPTH_WORDS];
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [31:0]          r_err_addr;

    logic [c_IDX_W-1:0]   w_inst_idx;
    logic [c_IDX_W-1:0]   w_data_idx;
    logic                 w_inst_in_range;
    logic                 w_data_in_range;
    logic                 w_inst_err;
    logic                 w_data_err;
    logic [31:0]          w_inst_mem_word;
    logic [31:0]          w_data_mem_word;
    logic                 w_inst_wr;
    logic                 w_data_wr;
    logic                 w_same_word;
    logic [31:0]          w_data_base;
    logic [31:0]          w_data_new;
    logic [ERR_CNT_W:0]   w_cnt_sum;

    assign w_inst_mem_word = r_mem[w_inst_idx];
    assign w_data_mem_word = r_mem[w_data_idx];

    sram_resp_port #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .OOR_DATA    (OOR_DATA),
        .IDX_W       (c_IDX_W)
    ) u_inst_port (
        .clk        (clk),
        .rst        (reset),
        .i_en       (inst_sram_en),
        .i_addr     (inst_sram_addr),
        .i_mem_word (w_inst_mem_word),
        .o_idx      (w_inst_idx),
        .o_in_range (w_inst_in_range),
        .o_err      (w_inst_err),
        .o_rdata    (inst_sram_rdata)
    );

    sram_resp_port #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS),
        .OOR_DATA    (OOR_DATA),
        .IDX_W       (c_IDX_W)
    ) u_data_port (
        .clk        (clk),
        .rst        (reset),
        .i_en       (data_sram_en),
        .i_addr     (data_sram_addr),
        .i_mem_word (w_data_mem_word),
        .o_idx      (w_data_idx),
        .o_in_range (w_data_in_range),
        .o_err      (w_data_err),
        .o_rdata    (data_sram_rdata)
    );

    assign w_inst_wr = inst_sram_en & inst_sram_we & w_inst_in_range & ~reset;
    assign w_data_wr = data_sram_en & (|data_sram_we) & w_data_in_range & ~reset;

    // On a same-word collision the data-port bytes are laid over the inst
    // write data, and the data write is issued last so it carries the merge.
    assign w_same_word = w_inst_wr && (w_inst_idx == w_data_idx);
    assign w_data_base = w_same_word ? inst_sram_wdata : w_data_mem_word;
    assign w_data_new  = merge_bytes(w_data_base, data_sram_wdata, data_sram_we);

    // No reset: array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_inst_wr) begin
            r_mem[w_inst_idx] <= inst_sram_wdata;
        end
        if (w_data_wr) begin
            r_mem[w_data_idx] <= w_data_new;
        end
    end

    assign w_cnt_sum = {1'b0, r_err_cnt}
                     + (ERR_CNT_W+1)'(w_inst_err)
                     + (ERR_CNT_W+1)'(w_data_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt  <= '0;
            r_err_addr <= 32'h0;
        end else begin
            if (w_cnt_sum[ERR_CNT_W]) begin
                r_err_cnt <= '1;
            end else begin
                r_err_cnt <= w_cnt_sum[ERR_CNT_W-1:0];
            end
            if (w_inst_err) begin
                r_err_addr <= inst_sram_addr;
            end else if (w_data_err) begin
                r_err_addr <= data_sram_addr;
            end
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_addr = r_err_addr;

endmodule
`default_nettype wire
